// File: rtl/ddr_rw_arbiter_if.sv
// ddr_rw_arbiter_if: request/status bus between the DDR read/write arbiter and its masters/FIFOs
interface ddr_rw_arbiter_if #(
    parameter int FIFO_CNT_W = 10
);
    logic                  addr_clr;
    logic [FIFO_CNT_W-1:0] wr_fifo_cnt;
    logic [FIFO_CNT_W-1:0] rd_fifo_space;
    logic                  wr_ready;
    logic                  wr_done;
    logic                  rd_ready;
    logic                  rd_done;
    logic                  wr_start;
    logic [29:0]           wr_addr;
    logic [7:0]            wr_len;
    logic                  rd_start;
    logic [29:0]           rd_addr;
    logic [7:0]            rd_len;
    logic                  busy;

    modport master (
        output addr_clr, wr_fifo_cnt, rd_fifo_space, wr_ready, wr_done, rd_ready, rd_done,
        input  wr_start, wr_addr, wr_len, rd_start, rd_addr, rd_len, busy
    );
    modport slave (
        input  addr_clr, wr_fifo_cnt, rd_fifo_space, wr_ready, wr_done, rd_ready, rd_done,
        output wr_start, wr_addr, wr_len, rd_start, rd_addr, rd_len, busy
    );
endinterface

// File: rtl/ddr_rw_arbiter.sv
// ddr_rw_arbiter: round-robin scheduling of AXI write/read bursts over a circular DDR region
module ddr_rw_arbiter #(
    parameter int          AXI_WIDTH  = 64,
    parameter logic [7:0]  BURST_LEN  = 8'd31,
    parameter int          FIFO_CNT_W = 10,
    parameter logic [29:0] ADDR_BEGIN = 30'd0,
    parameter logic [29:0] ADDR_END   = 30'd4096
) (
    input logic           clk,
    input logic           rst,
    ddr_rw_arbiter_if.slave bus
);
    localparam int BEATS       = int'(BURST_LEN) + 1;
    localparam int BURST_BYTES = BEATS * AXI_WIDTH / 8;
    localparam int CAPACITY    = (int'(ADDR_END) - int'(ADDR_BEGIN)) / BURST_BYTES;
    localparam int PW          = $clog2(CAPACITY + 1);

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_BUSY, RD_ISSUE, RD_BUSY} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pending;
    logic          last_wr, wr_req, rd_req, grant_wr, grant_rd, wr_fin, rd_fin;

    // 31-bit sum so the wrap compare cannot overflow near the top of the address space
    function automatic logic [29:0] advance(input logic [29:0] a);
        logic [30:0] s;
        s = {1'b0, a} + 31'(BURST_BYTES);
        return s >= {1'b0, ADDR_END} ? ADDR_BEGIN : s[29:0];
    endfunction

    assign wr_req   = bus.wr_fifo_cnt >= FIFO_CNT_W'(BEATS) && pending < PW'(CAPACITY) && bus.wr_ready;
    assign rd_req   = bus.rd_fifo_space >= FIFO_CNT_W'(BEATS) && pending != '0 && bus.rd_ready;
    assign grant_wr = state == IDLE && !bus.addr_clr && wr_req && (!rd_req || !last_wr);
    assign grant_rd = state == IDLE && !bus.addr_clr && rd_req && !grant_wr;
    assign wr_fin   = state == WR_BUSY && bus.wr_done;
    assign rd_fin   = state == RD_BUSY && bus.rd_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = grant_wr ? WR_ISSUE : grant_rd ? RD_ISSUE : IDLE;
            WR_ISSUE: state_nxt = WR_BUSY;
            WR_BUSY:  state_nxt = bus.wr_done ? IDLE : WR_BUSY;
            RD_ISSUE: state_nxt = RD_BUSY;
            RD_BUSY:  state_nxt = bus.rd_done ? IDLE : RD_BUSY;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.wr_start = state == WR_ISSUE;
        bus.rd_start = state == RD_ISSUE;
        bus.busy     = state != IDLE;
        bus.wr_len   = BURST_LEN;
        bus.rd_len   = BURST_LEN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wr_addr <= ADDR_BEGIN;
            bus.rd_addr <= ADDR_BEGIN;
            pending     <= '0;
            last_wr     <= 1'b0;
        end else if (state == IDLE && bus.addr_clr) begin
            bus.wr_addr <= ADDR_BEGIN;
            bus.rd_addr <= ADDR_BEGIN;
            pending     <= '0;
        end else begin
            if (grant_wr || grant_rd) last_wr <= grant_wr;
            if (wr_fin) begin
                pending     <= pending + PW'(1);
                bus.wr_addr <= advance(bus.wr_addr);
            end
            if (rd_fin) begin
                pending     <= pending - PW'(1);
                bus.rd_addr <= advance(bus.rd_addr);
            end
        end
    end
endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// tb_ddr_rw_arbiter: directed bench with a burst-level reference model and emulated AXI masters
module tb_ddr_rw_arbiter;
    localparam int BEATS = 32;
    localparam int BB    = 256;
    localparam int CAP   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_rw_arbiter_if #(.FIFO_CNT_W(10)) bif ();
    ddr_rw_arbiter dut (.clk(clk), .rst(rst), .bus(bif));

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = no burst, 1 = write burst, 2 = read burst; pointers kept as burst indices
    int   m_kind = 0, m_pending = 0, m_wi = 0, m_ri = 0;
    bit   m_issue = 0, m_last_wr = 0;
    logic wq, rq;
    assign wq = bif.wr_fifo_cnt >= 10'(BEATS) && m_pending < CAP && bif.wr_ready;
    assign rq = bif.rd_fifo_space >= 10'(BEATS) && m_pending > 0 && bif.rd_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_kind <= 0; m_issue <= 0; m_pending <= 0; m_wi <= 0; m_ri <= 0; m_last_wr <= 0;
        end else if (m_kind == 0) begin
            if (bif.addr_clr) begin
                m_wi <= 0; m_ri <= 0; m_pending <= 0;
            end else if (wq && (!rq || !m_last_wr)) begin
                m_kind <= 1; m_issue <= 1; m_last_wr <= 1;
            end else if (rq) begin
                m_kind <= 2; m_issue <= 1; m_last_wr <= 0;
            end
        end else if (m_issue) begin
            m_issue <= 0;
        end else if (m_kind == 1 && bif.wr_done) begin
            m_kind <= 0; m_pending <= m_pending + 1; m_wi <= (m_wi + 1) % CAP;
        end else if (m_kind == 2 && bif.rd_done) begin
            m_kind <= 0; m_pending <= m_pending - 1; m_ri <= (m_ri + 1) % CAP;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (!rst) begin
            check("cyc_wr_start", 32'(bif.wr_start), 32'(m_kind == 1 && m_issue));
            check("cyc_rd_start", 32'(bif.rd_start), 32'(m_kind == 2 && m_issue));
            check("cyc_busy", 32'(bif.busy), 32'(m_kind != 0));
            check("cyc_wr_addr", 32'(bif.wr_addr), 32'(m_wi * BB));
            check("cyc_rd_addr", 32'(bif.rd_addr), 32'(m_ri * BB));
            check("cyc_wr_len", 32'(bif.wr_len), 32'd31);
            check("cyc_rd_len", 32'(bif.rd_len), 32'd31);
        end
    end

    // Emulated masters: done pulse two cycles after the start pulse
    initial begin
        bif.wr_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bif.wr_start) begin
                repeat (2) @(negedge clk);
                bif.wr_done = 1'b1;
                @(negedge clk);
                bif.wr_done = 1'b0;
            end
        end
    end
    initial begin
        bif.rd_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bif.rd_start) begin
                repeat (2) @(negedge clk);
                bif.rd_done = 1'b1;
                @(negedge clk);
                bif.rd_done = 1'b0;
            end
        end
    end

    task automatic wait_start(input bit is_wr, input int exp_addr, output int lat);
        bit seen = 0;
        lat = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            seen = is_wr ? bif.wr_start : bif.rd_start;
        end
        check(is_wr ? "wr_start_seen" : "rd_start_seen", 32'(seen), 32'd1);
        if (seen) check(is_wr ? "wr_start_addr" : "rd_start_addr",
                        32'(is_wr ? bif.wr_addr : bif.rd_addr), 32'(exp_addr));
    endtask

    task automatic wait_none(input bit is_wr, input int n);
        bit seen = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (is_wr ? bif.wr_start : bif.rd_start) seen = 1;
        end
        check(is_wr ? "no_wr_start" : "no_rd_start", 32'(seen), 32'd0);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(posedge clk); #1;
            idle = !bif.busy;
        end
        check("idle_seen", 32'(idle), 32'd1);
    endtask

    initial begin
        int lat;
        bif.addr_clr      = 1'b0;
        bif.wr_fifo_cnt   = 10'd32;
        bif.rd_fifo_space = 10'd0;
        bif.wr_ready      = 1'b1;
        bif.rd_ready      = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_wr_start", 32'(bif.wr_start), 32'd0);
        check("rst_wr_addr", 32'(bif.wr_addr), 32'd0);
        check("rst_rd_addr", 32'(bif.rd_addr), 32'd0);
        check("rst_wr_len", 32'(bif.wr_len), 32'd31);
        check("rst_rd_len", 32'(bif.rd_len), 32'd31);
        rst = 1'b0;
        wait_start(1, 0, lat);
        check("first_wr_latency", 32'(lat), 32'd1);
        @(negedge clk) bif.wr_fifo_cnt = 10'd0;
        wait_idle();
        check("after_first_wr_addr", 32'(bif.wr_addr), 32'd256);

        // Round-robin: with both requesting, grants alternate starting from read
        @(negedge clk) bif.wr_fifo_cnt = 10'd32;
        wait_start(1, 256, lat);
        @(negedge clk) bif.rd_fifo_space = 10'd32;
        wait_start(0, 0, lat);
        wait_start(1, 512, lat);
        wait_start(0, 256, lat);
        @(negedge clk) bif.rd_fifo_space = 10'd0;

        // addr_clr held from WR_BUSY takes effect only in the IDLE after done
        wait_start(1, 768, lat);
        @(negedge clk) bif.addr_clr = 1'b1;
        wait_idle();
        check("clr_ignored_wr_addr", 32'(bif.wr_addr), 32'd1024);
        @(posedge clk); #1;
        check("clr_no_start", 32'(bif.wr_start), 32'd0);
        check("clr_wr_addr", 32'(bif.wr_addr), 32'd0);
        check("clr_rd_addr", 32'(bif.rd_addr), 32'd0);
        @(negedge clk);
        bif.addr_clr      = 1'b0;
        bif.wr_fifo_cnt   = 10'd0;
        bif.rd_fifo_space = 10'd32;
        wait_none(0, 10);

        // Fill to capacity: no 17th write, write pointer wraps
        @(negedge clk);
        bif.rd_fifo_space = 10'd0;
        bif.wr_fifo_cnt   = 10'd32;
        for (int i = 0; i < CAP; i++) wait_start(1, i * BB, lat);
        wait_none(1, 30);
        check("full_wr_wrap", 32'(bif.wr_addr), 32'd0);

        // Drain: reads walk the region and wrap, then stop at empty
        @(negedge clk);
        bif.wr_fifo_cnt   = 10'd0;
        bif.rd_fifo_space = 10'd32;
        for (int i = 0; i < CAP; i++) wait_start(0, i * BB, lat);
        wait_none(0, 30);
        check("empty_rd_wrap", 32'(bif.rd_addr), 32'd0);

        // Async reset in RD_BUSY
        @(negedge clk);
        bif.wr_fifo_cnt   = 10'd32;
        bif.rd_fifo_space = 10'd0;
        wait_start(1, 0, lat);
        @(negedge clk);
        bif.wr_fifo_cnt   = 10'd0;
        bif.rd_fifo_space = 10'd32;
        wait_start(0, 0, lat);
        repeat (2) @(negedge clk);
        check("pre_rst_wr_addr", 32'(bif.wr_addr), 32'd256);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bif.busy), 32'd0);
        check("arst_rd_start", 32'(bif.rd_start), 32'd0);
        check("arst_wr_addr", 32'(bif.wr_addr), 32'd0);
        check("arst_rd_addr", 32'(bif.rd_addr), 32'd0);
        @(negedge clk) rst = 1'b0;
        wait_none(0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
